// File: rtl/layer_compositor_if.sv
// Pixel, configuration and result signals shared between the sprite layers,
// the game engine and the layer compositor.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 12
);
    localparam int IW = $clog2(NUM_LAYERS);

    logic                            video_on;
    logic                            frame_start;
    logic [NUM_LAYERS-1:0]           layer_on;
    logic [NUM_LAYERS*COLOR_W-1:0]   layer_color;
    logic                            prio_wr;
    logic [IW-1:0]                   prio_slot;
    logic [IW-1:0]                   prio_layer;
    logic [NUM_LAYERS-1:0]           layer_en_shadow;
    logic                            collide_clr;
    logic [COLOR_W-1:0]              rgb;
    logic                            rgb_valid;
    logic [NUM_LAYERS*NUM_LAYERS-1:0] frame_collision;
    logic                            collision_irq;

    modport master (
        output video_on, frame_start, layer_on, layer_color,
               prio_wr, prio_slot, prio_layer, layer_en_shadow, collide_clr,
        input  rgb, rgb_valid, frame_collision, collision_irq
    );

    modport slave (
        input  video_on, frame_start, layer_on, layer_color,
               prio_wr, prio_slot, prio_layer, layer_en_shadow, collide_clr,
        output rgb, rgb_valid, frame_collision, collision_irq
    );
endinterface

// File: rtl/layer_compositor.sv
// Registered N-layer pixel mixer with frame-synchronous priority/enable tables
// and per-frame pairwise layer-overlap accumulation.
module layer_compositor #(
    parameter int                 NUM_LAYERS = 4,
    parameter int                 COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 12'h000
) (
    input  logic               vga_clk,
    input  logic               clrn,
    layer_compositor_if.slave  bus
);
    localparam int IW = $clog2(NUM_LAYERS);
    localparam int NN = NUM_LAYERS * NUM_LAYERS;

    typedef logic [IW-1:0] idx_t;

    idx_t                          shadow_prio [NUM_LAYERS];
    idx_t                          active_prio [NUM_LAYERS];
    idx_t                          shadow_next [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]         active_en;
    logic [NUM_LAYERS-1:0]         masked_on;
    logic [NN-1:0]                 hit_now;

    logic [NUM_LAYERS-1:0]         s1_on;
    logic [NUM_LAYERS*COLOR_W-1:0] s1_color;
    logic                          s1_video;
    logic [NN-1:0]                 s1_hit;

    logic [NN-1:0]                 acc;
    logic                          irq_arm;
    logic                          sel_found;
    logic [COLOR_W-1:0]            sel_color;

    // A write in the frame_start cycle must reach the active table too, so both
    // tables load from this merged view.
    always_comb begin
        shadow_next = shadow_prio;
        if (bus.prio_wr && (int'(bus.prio_slot) < NUM_LAYERS)) begin
            shadow_next[bus.prio_slot] = bus.prio_layer;
        end
    end

    assign masked_on = bus.layer_on & active_en;

    always_comb begin
        hit_now = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            for (int j = i + 1; j < NUM_LAYERS; j++) begin
                hit_now[i*NUM_LAYERS + j] = bus.video_on & masked_on[i] & masked_on[j];
            end
        end
    end

    // Layers missing from the table (or out-of-range entries) are simply never picked.
    always_comb begin
        sel_found = 1'b0;
        sel_color = BG_COLOR;
        for (int s = 0; s < NUM_LAYERS; s++) begin
            if (!sel_found && (int'(active_prio[s]) < NUM_LAYERS)) begin
                if (s1_on[active_prio[s]]) begin
                    sel_found = 1'b1;
                    sel_color = s1_color[int'(active_prio[s])*COLOR_W +: COLOR_W];
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            for (int s = 0; s < NUM_LAYERS; s++) begin
                shadow_prio[s] <= idx_t'(s);
                active_prio[s] <= idx_t'(s);
            end
            active_en <= '1;
        end else begin
            shadow_prio <= shadow_next;
            if (bus.frame_start) begin
                active_prio <= shadow_next;
                active_en   <= bus.layer_en_shadow;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            s1_on         <= '0;
            s1_color      <= '0;
            s1_video      <= 1'b0;
            s1_hit        <= '0;
            bus.rgb       <= '0;
            bus.rgb_valid <= 1'b0;
        end else begin
            s1_on         <= masked_on;
            s1_color      <= bus.layer_color;
            s1_video      <= bus.video_on;
            s1_hit        <= hit_now;
            bus.rgb       <= s1_video ? sel_color : '0;
            bus.rgb_valid <= s1_video;
        end
    end

    // frame_start takes precedence over collide_clr so a fresh frame result is never lost.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            acc                 <= '0;
            irq_arm             <= 1'b0;
            bus.frame_collision <= '0;
            bus.collision_irq   <= 1'b0;
        end else begin
            bus.collision_irq <= irq_arm;
            if (bus.frame_start) begin
                bus.frame_collision <= acc | s1_hit;
                acc                 <= '0;
                irq_arm             <= |(acc | s1_hit);
            end else begin
                acc     <= acc | s1_hit;
                irq_arm <= 1'b0;
                if (bus.collide_clr) begin
                    bus.frame_collision <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: vector table, directed frame sequences
// and randomized traffic against a per-pixel behavioural model.
module tb_layer_compositor;
    localparam int             NL = 4;
    localparam int             CW = 12;
    localparam int             NN = NL * NL;
    localparam logic [CW-1:0]  BG = 12'h123;
    localparam logic [NL*CW-1:0] COLS = {12'h00F, 12'hF00, 12'h0F0, 12'hF0F};

    logic vga_clk = 1'b0;
    logic clrn    = 1'b0;

    layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

    layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .BG_COLOR(BG)) dut (
        .vga_clk (vga_clk),
        .clrn    (clrn),
        .bus     (bus.slave)
    );

    always #5 vga_clk = ~vga_clk;

    int checks   = 0;
    int failures = 0;

    // Model of the compositor in terms of layers, slots and overlapping pairs.
    int            m_shadow [NL];
    int            m_prio   [NL];
    bit [NL-1:0]   m_en;
    bit            m_pair   [NL][NL];
    logic [CW-1:0] m_rgb_pend;
    bit            m_valid_pend;
    logic [NN-1:0] m_fc;
    bit            m_irq_arm;

    typedef struct {
        bit          vo;
        bit [NL-1:0] on;
        logic [CW-1:0] exp_rgb;
        bit          exp_valid;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int s = 0; s < NL; s++) begin
            m_shadow[s] = s;
            m_prio[s]   = s;
            for (int j = 0; j < NL; j++) m_pair[s][j] = 1'b0;
        end
        m_en         = '1;
        m_rgb_pend   = '0;
        m_valid_pend = 1'b0;
        m_fc         = '0;
        m_irq_arm    = 1'b0;
    endtask

    function automatic logic [CW-1:0] modelPixel(input bit vo, input bit [NL-1:0] on,
                                                 input logic [NL*CW-1:0] col);
        if (!vo) return '0;
        for (int s = 0; s < NL; s++) begin
            if (on[m_prio[s]] && m_en[m_prio[s]]) return col[m_prio[s]*CW +: CW];
        end
        return BG;
    endfunction

    function automatic logic [NN-1:0] pairVec();
        logic [NN-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++)
            for (int j = 0; j < NL; j++)
                if (m_pair[i][j]) v[i*NL + j] = 1'b1;
        return v;
    endfunction

    task automatic setIdle();
        bus.video_on    = 1'b0;
        bus.frame_start = 1'b0;
        bus.layer_on    = '0;
        bus.layer_color = COLS;
        bus.prio_wr     = 1'b0;
        bus.prio_slot   = '0;
        bus.prio_layer  = '0;
        bus.collide_clr = 1'b0;
    endtask

    // One pixel cycle: advance the model with the driven inputs, clock, then compare.
    task automatic applyStimulus();
        logic [CW-1:0] exp_rgb;
        bit            exp_valid;
        bit            exp_irq;
        exp_rgb   = m_rgb_pend;
        exp_valid = m_valid_pend;
        exp_irq   = m_irq_arm;

        m_rgb_pend   = modelPixel(bus.video_on, bus.layer_on, bus.layer_color);
        m_valid_pend = bus.video_on;
        if (bus.prio_wr) m_shadow[bus.prio_slot] = int'(bus.prio_layer);
        m_irq_arm = 1'b0;
        if (bus.frame_start) begin
            m_fc      = pairVec();
            m_irq_arm = (m_fc != '0);
            for (int i = 0; i < NL; i++)
                for (int j = 0; j < NL; j++) m_pair[i][j] = 1'b0;
        end else if (bus.collide_clr) begin
            m_fc = '0;
        end
        if (bus.video_on) begin
            for (int i = 0; i < NL; i++)
                for (int j = i + 1; j < NL; j++)
                    if (bus.layer_on[i] && m_en[i] && bus.layer_on[j] && m_en[j])
                        m_pair[i][j] = 1'b1;
        end
        if (bus.frame_start) begin
            m_prio = m_shadow;
            m_en   = bus.layer_en_shadow;
        end

        @(posedge vga_clk);
        #1;
        checkOutput("rgb", 32'(bus.rgb), 32'(exp_rgb));
        checkOutput("rgb_valid", 32'(bus.rgb_valid), 32'(exp_valid));
        checkOutput("frame_collision", 32'(bus.frame_collision), 32'(m_fc));
        checkOutput("collision_irq", 32'(bus.collision_irq), 32'(exp_irq));
    endtask

    task automatic pixelExpect(input string name, input bit [NL-1:0] on, input logic [CW-1:0] exp);
        bus.video_on = 1'b1;
        bus.layer_on = on;
        applyStimulus();
        bus.video_on = 1'b0;
        bus.layer_on = '0;
        applyStimulus();
        checkOutput(name, 32'(bus.rgb), 32'(exp));
    endtask

    task automatic pulseFrame(input bit clr);
        bus.video_on    = 1'b0;
        bus.layer_on    = '0;
        bus.frame_start = 1'b1;
        bus.collide_clr = clr;
        applyStimulus();
        bus.frame_start = 1'b0;
        bus.collide_clr = 1'b0;
    endtask

    task automatic doReset();
        #3;
        clrn = 1'b0;
        #1;
        checkOutput("rst_rgb", 32'(bus.rgb), 32'h0);
        checkOutput("rst_valid", 32'(bus.rgb_valid), 32'h0);
        checkOutput("rst_fc", 32'(bus.frame_collision), 32'h0);
        checkOutput("rst_irq", 32'(bus.collision_irq), 32'h0);
        modelReset();
        setIdle();
        bus.layer_en_shadow = '1;
        repeat (2) @(posedge vga_clk);
        #1;
        clrn = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b1010, 12'h0F0, 1'b1};
        vecs[1] = '{1'b0, 4'b1111, 12'h000, 1'b0};
        vecs[2] = '{1'b1, 4'b0000, BG,      1'b1};
        vecs[3] = '{1'b1, 4'b1111, 12'hF0F, 1'b1};
        vecs[4] = '{1'b1, 4'b1000, 12'h00F, 1'b1};
        vecs[5] = '{1'b1, 4'b0100, 12'hF00, 1'b1};
        vecs[6] = '{1'b1, 4'b1100, 12'hF00, 1'b1};
        vecs[7] = '{1'b1, 4'b0001, 12'hF0F, 1'b1};

        setIdle();
        bus.layer_en_shadow = '1;
        modelReset();
        repeat (2) @(posedge vga_clk);
        #1;
        checkOutput("init_rgb", 32'(bus.rgb), 32'h0);
        checkOutput("init_fc", 32'(bus.frame_collision), 32'h0);
        clrn = 1'b1;

        $display("[TB] vector table, reset-default configuration");
        for (int v = 0; v < 8; v++) begin
            bus.video_on = vecs[v].vo;
            bus.layer_on = vecs[v].on;
            applyStimulus();
            bus.video_on = 1'b0;
            bus.layer_on = '0;
            applyStimulus();
            checkOutput($sformatf("tbl%0d_rgb", v), 32'(bus.rgb), 32'(vecs[v].exp_rgb));
            checkOutput($sformatf("tbl%0d_valid", v), 32'(bus.rgb_valid), 32'(vecs[v].exp_valid));
        end

        $display("[TB] shadow table isolation");
        bus.video_on   = 1'b1;
        bus.layer_on   = 4'b1010;
        bus.prio_wr    = 1'b1;
        bus.prio_slot  = 2'd0;
        bus.prio_layer = 2'd3;
        applyStimulus();
        bus.prio_slot  = 2'd3;
        bus.prio_layer = 2'd0;
        applyStimulus();
        bus.prio_wr = 1'b0;
        pixelExpect("iso_pre", 4'b1010, 12'h0F0);
        pulseFrame(1'b0);
        pixelExpect("iso_post", 4'b1010, 12'h00F);

        $display("[TB] reset mid-line");
        pulseFrame(1'b0);
        bus.video_on = 1'b1;
        bus.layer_on = 4'b1010;
        applyStimulus();
        applyStimulus();
        doReset();
        pixelExpect("rst_ident_a", 4'b1010, 12'h0F0);
        pixelExpect("rst_ident_b", 4'b1001, 12'hF0F);

        $display("[TB] collision accumulation");
        doReset();
        pixelExpect("coll_pix", 4'b0101, 12'hF0F);
        pulseFrame(1'b0);
        checkOutput("coll_fc", 32'(bus.frame_collision), 32'h0004);
        checkOutput("coll_irq_early", 32'(bus.collision_irq), 32'h0);
        applyStimulus();
        checkOutput("coll_irq_pulse", 32'(bus.collision_irq), 32'h1);
        applyStimulus();
        checkOutput("coll_irq_end", 32'(bus.collision_irq), 32'h0);
        pixelExpect("coll_pix2", 4'b1010, 12'h0F0);
        pulseFrame(1'b1);
        checkOutput("clr_vs_fs", 32'(bus.frame_collision), 32'h0080);
        applyStimulus();
        applyStimulus();
        bus.collide_clr = 1'b1;
        applyStimulus();
        bus.collide_clr = 1'b0;
        checkOutput("clr_only", 32'(bus.frame_collision), 32'h0);
        pulseFrame(1'b0);
        pulseFrame(1'b0);
        checkOutput("b2b_empty", 32'(bus.frame_collision), 32'h0);

        $display("[TB] layer enables");
        doReset();
        bus.layer_en_shadow = 4'b1110;
        pulseFrame(1'b0);
        pixelExpect("en_l1", 4'b0011, 12'h0F0);
        pixelExpect("en_l0_only", 4'b0001, BG);
        pixelExpect("en_02", 4'b0101, 12'hF00);
        pixelExpect("en_12", 4'b0110, 12'h0F0);
        pulseFrame(1'b0);
        checkOutput("en_fc", 32'(bus.frame_collision), 32'h0040);

        $display("[TB] randomized traffic");
        doReset();
        for (int n = 0; n < 800; n++) begin
            bus.frame_start = ($urandom_range(0, 39) == 0);
            bus.video_on    = bus.frame_start ? 1'b0 : ($urandom_range(0, 3) != 0);
            bus.layer_on    = 4'($urandom());
            bus.layer_color = 48'({$urandom(), $urandom()});
            bus.prio_wr     = ($urandom_range(0, 7) == 0);
            bus.prio_slot   = 2'($urandom());
            bus.prio_layer  = 2'($urandom());
            if ($urandom_range(0, 15) == 0) bus.layer_en_shadow = 4'($urandom());
            bus.collide_clr = ($urandom_range(0, 29) == 0);
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised pixel compositor between the per-layer sprite engines (background, tanks, bullets, further layers) and the VGA controller's `d_in`. It replaces a fixed combinational priority chain with a registered N-layer mixer. The mixer has a runtime-programmable priority table and per-layer enables, both double-buffered and applied only at frame start. It also accumulates per-frame pairwise layer-overlap flags, which feed hit detection in the game engine.

## Interface
Parameters:
- `NUM_LAYERS`, default 4: number of input layers, 2..8; layer 0 is tank1 by convention.
- `COLOR_W`, default 12: RGB width per pixel.
- `BG_COLOR`, default 12'h000: output colour when no enabled layer is on.
- `IW`, derived as $clog2(NUM_LAYERS): width of the layer-index fields.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `vga_clk`  in  1  pixel clock.
  - `clrn`  in  1  asynchronous active-low reset.
- Pixel path:
  - `video_on`  in  1  active-area qualifier, aligned with the layer inputs.
  - `frame_start`  in  1  one-cycle pulse during vertical blank.
  - `layer_on`  in  NUM_LAYERS  per-layer pixel hit.
  - `layer_color`  in  NUM_LAYERS*COLOR_W  layer i occupies bits [i*COLOR_W +: COLOR_W].
- Configuration (shadow, applied at frame start):
  - `prio_wr`  in  1  write strobe for the shadow priority table.
  - `prio_slot`  in  IW  slot to write; slot 0 is the highest priority.
  - `prio_layer`  in  IW  layer index stored in that slot.
  - `layer_en_shadow`  in  NUM_LAYERS  enables, sampled at frame start.
  - `collide_clr`  in  1  clears `frame_collision`.
- Outputs:
  - `rgb`  out  COLOR_W  composited pixel, delayed 2 cycles.
  - `rgb_valid`  out  1  `video_on` delayed 2 cycles.
  - `frame_collision`  out  NUM_LAYERS*NUM_LAYERS  bit [i*NUM_LAYERS+j] is set only for i<j; all other bits are always 0.
  - `collision_irq`  out  1  one-cycle pulse.

## Operation
- Tables:
  - Active and shadow priority tables each hold NUM_LAYERS entries of IW bits.
  - Reset value of both tables: slot s holds layer s (identity).
  - Reset value of active and shadow enables: all 1s.
- Stage 1 registers:
  - `layer_on` AND'ed with the active enables.
  - `layer_color`.
  - `video_on`.
  - The pairwise hit vector: hit(i,j) = video_on & on_i & en_i & on_j & en_j, for i<j.
- Stage 2 selection:
  - Scan slots 0..NUM_LAYERS-1 and pick the first slot whose layer is on.
  - `rgb` <= that layer's colour, or BG_COLOR if no slot matches.
  - `rgb` is forced to 0 when the stage-1 `video_on` is 0.
  - `rgb_valid` <= stage-1 `video_on`.
- Table contents:
  - Duplicate layer entries are legal; the first slot holding the layer wins.
  - A layer absent from the table is never displayed, but still participates in collision.
- Shadow writes: on `prio_wr`, shadow[prio_slot] <= prio_layer.
- On `frame_start`, all of the following happen in the same cycle:
  - The active table is loaded from the shadow table. If `prio_wr` is high in the same cycle, the new write is included.
  - The active enables are loaded from `layer_en_shadow`.
  - `frame_collision` <= accumulator | stage-1 hit vector.
  - The accumulator is cleared.
  - `collision_irq` is asserted on the next cycle if the latched value is nonzero.
- Between frame starts, the accumulator ORs in the stage-1 hit vector every cycle.
- `collide_clr` zeroes `frame_collision`. If `collide_clr` coincides with `frame_start`, `frame_start` wins.

## Timing
- Latency: `rgb` and `rgb_valid` trail the inputs by exactly 2 `vga_clk` cycles. Throughput is one pixel per cycle with no stalls.
- The configuration change takes effect on the first pixel sampled the cycle after the `frame_start` pulse.
- `frame_collision` updates one cycle after `frame_start` is sampled. `collision_irq` is high for exactly one cycle, on the cycle after that update.
- Reset (asynchronous, may be asserted at any time, including mid-line):
  - Outputs: `rgb`=0, `rgb_valid`=0, `frame_collision`=0, `collision_irq`=0.
  - Internal state: pipeline, accumulator and both tables return to their reset values.
  - The first valid output appears 2 cycles after the first `video_on` sampled following reset release.
- Back-to-back `frame_start` pulses are legal. The second pulse latches only the hits from the intervening cycle.

## Test plan
- Reset defaults, NUM_LAYERS=4:
  - Stimulus: layer_on=4'b1010, colours L1=12'h0F0 and L3=12'h00F, video_on=1.
  - Required: rgb=12'h0F0 two cycles later, with rgb_valid=1.
- Shadow isolation:
  - Stimulus: write slot0=3 and slot3=0 mid-frame.
  - Required: output stays 12'h0F0 until `frame_start`; after `frame_start`, the same inputs give 12'h00F.
- Blanking and background:
  - Stimulus 1: video_on=0 with layer_on=4'b1111. Required: rgb=0 and rgb_valid=0.
  - Stimulus 2: video_on=1 with layer_on=0. Required: rgb=BG_COLOR.
- Collision accumulation:
  - Stimulus: layers 0 and 2 overlap for one pixel; then `frame_start`.
  - Required: frame_collision has only bit 2 (i=0, j=2) set; collision_irq pulses once.
  - Stimulus: `collide_clr` asserted together with the next `frame_start`.
  - Required: the newly latched value is kept, not cleared.
- Enables:
  - Stimulus: layer_en_shadow=4'b1110, then `frame_start`.
  - Required: layer 0 is never displayed and is excluded from collisions; layer 1 is displayed wherever it is on.
- Reset mid-line:
  - Stimulus: assert `clrn`=0 asynchronously while video_on=1.
  - Required: all outputs go to 0 immediately; the priority table returns to identity.
